// File: rtl/memory_pkg.sv
// Shared constants and helpers for the pipelined dual-port memory.
package memory_pkg;

    localparam int unsigned BYTEWIDTH    = 8;

    // Same-address read-during-write selection values for RDWMODE.
    localparam int unsigned RDW_OLD_DATA = 0;
    localparam int unsigned RDW_NEW_DATA = 1;

    // Number of byte lanes in a word of the given width.
    function automatic int unsigned lane_count(input int unsigned width);
        return width / BYTEWIDTH;
    endfunction

endpackage

// File: rtl/sdp_ram_bank.sv
// One byte lane of the memory: a simple dual-port RAM with one write port and
// one registered read port. A same-address collision reads the pre-write word.
module sdp_ram_bank
    import memory_pkg::*;
#(
    parameter int unsigned WIDTH        = BYTEWIDTH,
    parameter int unsigned DEPTH        = 1024,
    parameter int unsigned ADDRESSWIDTH = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    write_en,
    input  logic [ADDRESSWIDTH-1:0] write_address,
    input  logic [WIDTH-1:0]        write_data,
    input  logic                    read_en,
    input  logic [ADDRESSWIDTH-1:0] read_address,
    output logic [WIDTH-1:0]        read_data
);

    // Contents start at zero in simulation; reset never clears them.
    logic [WIDTH-1:0] mem [DEPTH] = '{default: '0};
    logic [WIDTH-1:0] read_data_q;

    // Write port; callers only enable it for in-range addresses.
    always_ff @(posedge clk) begin
        if (write_en) begin
            mem[write_address] <= write_data;
        end
    end

    // Registered read port; holds its value when not enabled.
    always_ff @(posedge clk) begin
        if (read_en) begin
            read_data_q <= mem[read_address];
        end
    end

    assign read_data = read_data_q;

endmodule

// File: rtl/pipelined_dual_port_memory.sv
// Byte-lane-writable dual-port memory with a 1- or 2-cycle pipelined read port.
// Out-of-range writes are dropped and out-of-range reads return zero.
// Optional feature: define PIPELINED_DUAL_PORT_MEMORY_PARITY_EN to store one even
// parity bit per byte lane and add the parity_inject / parity_error ports.
module pipelined_dual_port_memory
    import memory_pkg::*;
#(
    parameter int unsigned DATAWIDTH    = 32,
    parameter int unsigned DATADEPTH    = 1024,
    parameter int unsigned ADDRESSWIDTH = $clog2(DATADEPTH),
    parameter int unsigned READLATENCY  = 1,
    parameter int unsigned RDWMODE      = RDW_OLD_DATA
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      write_en,
    input  logic [DATAWIDTH/8-1:0]    write_byte_en,
    input  logic [ADDRESSWIDTH-1:0]   write_address,
    input  logic [DATAWIDTH-1:0]      data_in,
    input  logic                      read_en,
    input  logic [ADDRESSWIDTH-1:0]   read_address,
`ifdef PIPELINED_DUAL_PORT_MEMORY_PARITY_EN
    input  logic                      parity_inject,
    output logic                      parity_error,
`endif
    output logic [DATAWIDTH-1:0]      data_out,
    output logic                      data_out_valid
);

    localparam int unsigned LANES = lane_count(DATAWIDTH);
`ifdef PIPELINED_DUAL_PORT_MEMORY_PARITY_EN
    localparam int unsigned LANEWIDTH = BYTEWIDTH + 1;
`else
    localparam int unsigned LANEWIDTH = BYTEWIDTH;
`endif
    // One extra bit so DATADEPTH itself is representable for the range check.
    localparam logic [ADDRESSWIDTH:0] DEPTH_LIMIT = (ADDRESSWIDTH + 1)'(DATADEPTH);

    if ((DATAWIDTH == 0) || ((DATAWIDTH % BYTEWIDTH) != 0) ||
        ((READLATENCY != 1) && (READLATENCY != 2)) ||
        ((RDWMODE != RDW_OLD_DATA) && (RDWMODE != RDW_NEW_DATA))) begin : g_param_check
        $fatal(1, "pipelined_dual_port_memory: illegal DATAWIDTH, READLATENCY or RDWMODE");
    end

    logic                 write_in_range;
    logic                 read_in_range;
    logic                 write_ok;
    logic                 read_ok;
    logic                 bank_read_en;
    logic                 fwd_hit;
    logic [LANES-1:0]     lane_we;
    logic [LANEWIDTH-1:0] lane_wdata [LANES];
    logic [LANEWIDTH-1:0] lane_rdata [LANES];

    // First read stage: sideband that travels alongside the bank read.
    logic                 valid1_q;
    logic                 oob1_q;
    logic [LANES-1:0]     fwd_mask_q;
    logic [LANEWIDTH-1:0] fwd_data_q [LANES];

    logic [LANEWIDTH-1:0] lane_sel;
    logic [DATAWIDTH-1:0] word1;
`ifdef PIPELINED_DUAL_PORT_MEMORY_PARITY_EN
    logic [LANES-1:0]     lane_err1;
    logic                 perr1;
`endif

    assign write_in_range = {1'b0, write_address} < DEPTH_LIMIT;
    assign read_in_range  = {1'b0, read_address} < DEPTH_LIMIT;
    assign write_ok       = write_en & ~reset & write_in_range;
    assign read_ok        = read_en & ~reset;
    assign bank_read_en   = read_ok & read_in_range;
    assign fwd_hit        = (RDWMODE == RDW_NEW_DATA) && write_ok && bank_read_en &&
                            (write_address == read_address);

    // Split the write word into lanes, appending the stored parity bit if enabled.
    always_comb begin
        lane_we = '0;
        for (int i = 0; i < LANES; i++) begin
`ifdef PIPELINED_DUAL_PORT_MEMORY_PARITY_EN
            lane_wdata[i] = {(^data_in[i*BYTEWIDTH +: BYTEWIDTH]) ^ parity_inject,
                             data_in[i*BYTEWIDTH +: BYTEWIDTH]};
`else
            lane_wdata[i] = data_in[i*BYTEWIDTH +: BYTEWIDTH];
`endif
            lane_we[i] = write_ok & write_byte_en[i];
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        sdp_ram_bank #(
            .WIDTH        (LANEWIDTH),
            .DEPTH        (DATADEPTH),
            .ADDRESSWIDTH (ADDRESSWIDTH)
        ) u_bank (
            .clk           (clk),
            .write_en      (lane_we[g]),
            .write_address (write_address),
            .write_data    (lane_wdata[g]),
            .read_en       (bank_read_en),
            .read_address  (read_address),
            .read_data     (lane_rdata[g])
        );
    end

    // Stage-1 control: reset flushes any read in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid1_q   <= 1'b0;
            oob1_q     <= 1'b0;
            fwd_mask_q <= '0;
        end else begin
            valid1_q   <= read_ok;
            oob1_q     <= ~read_in_range;
            fwd_mask_q <= fwd_hit ? write_byte_en : '0;
        end
    end

    // Capture the colliding write so new-data mode can bypass the bank's old word.
    always_ff @(posedge clk) begin
        if (fwd_hit) begin
            for (int i = 0; i < LANES; i++) begin
                fwd_data_q[i] <= lane_wdata[i];
            end
        end
    end

    // Assemble the returned word: forwarded lanes win, out-of-range reads give zero.
    always_comb begin
        word1    = '0;
        lane_sel = '0;
`ifdef PIPELINED_DUAL_PORT_MEMORY_PARITY_EN
        lane_err1 = '0;
`endif
        for (int i = 0; i < LANES; i++) begin
            lane_sel = fwd_mask_q[i] ? fwd_data_q[i] : lane_rdata[i];
            if (!oob1_q) begin
                word1[i*BYTEWIDTH +: BYTEWIDTH] = lane_sel[BYTEWIDTH-1:0];
`ifdef PIPELINED_DUAL_PORT_MEMORY_PARITY_EN
                lane_err1[i] = ^lane_sel;
`endif
            end
        end
    end

`ifdef PIPELINED_DUAL_PORT_MEMORY_PARITY_EN
    assign perr1 = valid1_q & (|lane_err1);
`endif

    if (READLATENCY == 1) begin : g_lat1
        logic [DATAWIDTH-1:0] hold_q;

        // Remember the last returned word so data_out holds between reads.
        always_ff @(posedge clk) begin
            if (reset) begin
                hold_q <= '0;
            end else if (valid1_q) begin
                hold_q <= word1;
            end
        end

        assign data_out       = valid1_q ? word1 : hold_q;
        assign data_out_valid = valid1_q;
`ifdef PIPELINED_DUAL_PORT_MEMORY_PARITY_EN
        assign parity_error   = perr1;
`endif
    end else begin : g_lat2
        logic [DATAWIDTH-1:0] data_out_q;
        logic                 valid2_q;
`ifdef PIPELINED_DUAL_PORT_MEMORY_PARITY_EN
        logic                 perr2_q;
`endif

        // Output register stage; updates only when a read completes.
        always_ff @(posedge clk) begin
            if (reset) begin
                data_out_q <= '0;
                valid2_q   <= 1'b0;
`ifdef PIPELINED_DUAL_PORT_MEMORY_PARITY_EN
                perr2_q    <= 1'b0;
`endif
            end else begin
                valid2_q <= valid1_q;
`ifdef PIPELINED_DUAL_PORT_MEMORY_PARITY_EN
                perr2_q  <= perr1;
`endif
                if (valid1_q) begin
                    data_out_q <= word1;
                end
            end
        end

        assign data_out       = data_out_q;
        assign data_out_valid = valid2_q;
`ifdef PIPELINED_DUAL_PORT_MEMORY_PARITY_EN
        assign parity_error   = perr2_q;
`endif
    end

endmodule

// File: tb/tb_pipelined_dual_port_memory.sv
// Bench for pipelined_dual_port_memory. Two instances share one stimulus stream:
// dut_a is READLATENCY=2 / old-data, dut_b is READLATENCY=1 / new-data, both 1000 deep.
module tb_pipelined_dual_port_memory;

    localparam int DW = 32;
    localparam int DD = 1000;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          write_en;
    logic [3:0]    write_byte_en;
    logic [AW-1:0] write_address;
    logic [DW-1:0] data_in;
    logic          read_en;
    logic [AW-1:0] read_address;
    logic [DW-1:0] dout_a;
    logic [DW-1:0] dout_b;
    logic          vld_a;
    logic          vld_b;
`ifdef PIPELINED_DUAL_PORT_MEMORY_PARITY_EN
    logic          parity_inject;
    logic          perr_a;
    logic          perr_b;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipelined_dual_port_memory #(
        .DATAWIDTH (DW), .DATADEPTH (DD), .ADDRESSWIDTH (AW), .READLATENCY (2), .RDWMODE (0)
    ) dut_a (
        .clk            (clk),
        .reset          (reset),
        .write_en       (write_en),
        .write_byte_en  (write_byte_en),
        .write_address  (write_address),
        .data_in        (data_in),
        .read_en        (read_en),
        .read_address   (read_address),
`ifdef PIPELINED_DUAL_PORT_MEMORY_PARITY_EN
        .parity_inject  (parity_inject),
        .parity_error   (perr_a),
`endif
        .data_out       (dout_a),
        .data_out_valid (vld_a)
    );

    pipelined_dual_port_memory #(
        .DATAWIDTH (DW), .DATADEPTH (DD), .ADDRESSWIDTH (AW), .READLATENCY (1), .RDWMODE (1)
    ) dut_b (
        .clk            (clk),
        .reset          (reset),
        .write_en       (write_en),
        .write_byte_en  (write_byte_en),
        .write_address  (write_address),
        .data_in        (data_in),
        .read_en        (read_en),
        .read_address   (read_address),
`ifdef PIPELINED_DUAL_PORT_MEMORY_PARITY_EN
        .parity_inject  (parity_inject),
        .parity_error   (perr_b),
`endif
        .data_out       (dout_b),
        .data_out_valid (vld_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        write_en      = 1'b0;
        write_byte_en = 4'h0;
        read_en       = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic [3:0] be);
        write_en      = 1'b1;
        write_address = addr;
        data_in       = data;
        write_byte_en = be;
        tick();
        idle();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({vld_a, dout_a} !== 33'h0) begin
            failures++;
            $display("FAIL reset_a: got valid=%b data=%h want valid=0 data=0", vld_a, dout_a);
        end
        checks++;
        if ({vld_b, dout_b} !== 33'h0) begin
            failures++;
            $display("FAIL reset_b: got valid=%b data=%h want valid=0 data=0", vld_b, dout_b);
        end
        reset = 1'b0;
        tick();
        checks++;
        if ({vld_a, vld_b} !== 2'b00) begin
            failures++;
            $display("FAIL idle_after_reset: got valid_a=%b valid_b=%b want 0 0", vld_a, vld_b);
        end
    endtask

    task automatic test_write_read();
        do_write(10'd5, 32'hDEADBEEF, 4'hF);
        read_en      = 1'b1;
        read_address = 10'd5;
        tick();
        idle();
        checks++;
        if ({vld_b, dout_b} !== {1'b1, 32'hDEADBEEF}) begin
            failures++;
            $display("FAIL lat1_read: got valid=%b data=%h want valid=1 data=deadbeef",
                     vld_b, dout_b);
        end
        checks++;
        if (vld_a !== 1'b0) begin
            failures++;
            $display("FAIL lat2_early: got valid=%b want 0 one cycle after read", vld_a);
        end
        tick();
        checks++;
        if ({vld_a, dout_a} !== {1'b1, 32'hDEADBEEF}) begin
            failures++;
            $display("FAIL lat2_read: got valid=%b data=%h want valid=1 data=deadbeef",
                     vld_a, dout_a);
        end
        checks++;
        if ({vld_b, dout_b} !== {1'b0, 32'hDEADBEEF}) begin
            failures++;
            $display("FAIL lat1_hold: got valid=%b data=%h want valid=0 data=deadbeef",
                     vld_b, dout_b);
        end
        tick();
        checks++;
        if ({vld_a, dout_a} !== {1'b0, 32'hDEADBEEF}) begin
            failures++;
            $display("FAIL lat2_hold: got valid=%b data=%h want valid=0 data=deadbeef",
                     vld_a, dout_a);
        end
    endtask

    task automatic test_rdw();
        // Same-address collision with partial byte enables.
        write_en      = 1'b1;
        write_address = 10'd5;
        data_in       = 32'h11223344;
        write_byte_en = 4'b0101;
        read_en       = 1'b1;
        read_address  = 10'd5;
        tick();
        idle();
        checks++;
        if ({vld_b, dout_b} !== {1'b1, 32'hDE22BE44}) begin
            failures++;
            $display("FAIL rdw_new: got valid=%b data=%h want valid=1 data=de22be44",
                     vld_b, dout_b);
        end
        tick();
        checks++;
        if ({vld_a, dout_a} !== {1'b1, 32'hDEADBEEF}) begin
            failures++;
            $display("FAIL rdw_old: got valid=%b data=%h want valid=1 data=deadbeef",
                     vld_a, dout_a);
        end
        // Write to address 6 while reading 5: the read must be untouched.
        write_en      = 1'b1;
        write_address = 10'd6;
        data_in       = 32'hCAFEF00D;
        write_byte_en = 4'hF;
        read_en       = 1'b1;
        read_address  = 10'd5;
        tick();
        idle();
        checks++;
        if ({vld_b, dout_b} !== {1'b1, 32'hDE22BE44}) begin
            failures++;
            $display("FAIL merged_b: got valid=%b data=%h want valid=1 data=de22be44",
                     vld_b, dout_b);
        end
        tick();
        checks++;
        if ({vld_a, dout_a} !== {1'b1, 32'hDE22BE44}) begin
            failures++;
            $display("FAIL merged_a: got valid=%b data=%h want valid=1 data=de22be44",
                     vld_a, dout_a);
        end
        read_en      = 1'b1;
        read_address = 10'd6;
        tick();
        idle();
        checks++;
        if ({vld_b, dout_b} !== {1'b1, 32'hCAFEF00D}) begin
            failures++;
            $display("FAIL other_addr: got valid=%b data=%h want valid=1 data=cafef00d",
                     vld_b, dout_b);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] exp;
        for (int i = 0; i < 8; i++) begin
            do_write(10'(i), 32'hC0DE0000 | 32'(i), 4'hF);
        end
        for (int k = 0; k < 9; k++) begin
            read_en      = (k < 8);
            read_address = 10'(k);
            tick();
            if (k < 8) begin
                exp = 32'hC0DE0000 | 32'(k);
                checks++;
                if ({vld_b, dout_b} !== {1'b1, exp}) begin
                    failures++;
                    $display("FAIL b2b_b[%0d]: got valid=%b data=%h want valid=1 data=%h",
                             k, vld_b, dout_b, exp);
                end
            end else begin
                checks++;
                if (vld_b !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_b_end: got valid=%b want 0", vld_b);
                end
            end
            if (k > 0) begin
                exp = 32'hC0DE0000 | 32'(k - 1);
                checks++;
                if ({vld_a, dout_a} !== {1'b1, exp}) begin
                    failures++;
                    $display("FAIL b2b_a[%0d]: got valid=%b data=%h want valid=1 data=%h",
                             k - 1, vld_a, dout_a, exp);
                end
            end
        end
        idle();
        tick();
        checks++;
        if (vld_a !== 1'b0) begin
            failures++;
            $display("FAIL b2b_a_end: got valid=%b want 0", vld_a);
        end
    endtask

    task automatic test_out_of_range();
        do_write(10'd999, 32'h99999999, 4'hF);
        do_write(10'd1010, 32'hFFFFFFFF, 4'hF);
        do_write(10'd999, 32'h00000000, 4'h0);
        read_en      = 1'b1;
        read_address = 10'd1010;
        tick();
        idle();
        checks++;
        if ({vld_b, dout_b} !== {1'b1, 32'h0}) begin
            failures++;
            $display("FAIL oob_read_b: got valid=%b data=%h want valid=1 data=0", vld_b, dout_b);
        end
        tick();
        checks++;
        if ({vld_a, dout_a} !== {1'b1, 32'h0}) begin
            failures++;
            $display("FAIL oob_read_a: got valid=%b data=%h want valid=1 data=0", vld_a, dout_a);
        end
        read_en      = 1'b1;
        read_address = 10'd999;
        tick();
        idle();
        checks++;
        if ({vld_b, dout_b} !== {1'b1, 32'h99999999}) begin
            failures++;
            $display("FAIL last_word_b: got valid=%b data=%h want valid=1 data=99999999",
                     vld_b, dout_b);
        end
        tick();
        checks++;
        if ({vld_a, dout_a} !== {1'b1, 32'h99999999}) begin
            failures++;
            $display("FAIL last_word_a: got valid=%b data=%h want valid=1 data=99999999",
                     vld_a, dout_a);
        end
    endtask

    task automatic test_reset_flush();
        read_en      = 1'b1;
        read_address = 10'd7;
        tick();
        // Reset arrives with a new read and a write pending; both must be ignored.
        reset         = 1'b1;
        read_en       = 1'b1;
        read_address  = 10'd999;
        write_en      = 1'b1;
        write_address = 10'd999;
        data_in       = 32'h0;
        write_byte_en = 4'hF;
        tick();
        idle();
        checks++;
        if ({vld_a, dout_a} !== 33'h0) begin
            failures++;
            $display("FAIL flush_a: got valid=%b data=%h want valid=0 data=0", vld_a, dout_a);
        end
        checks++;
        if ({vld_b, dout_b} !== 33'h0) begin
            failures++;
            $display("FAIL flush_b: got valid=%b data=%h want valid=0 data=0", vld_b, dout_b);
        end
        reset = 1'b0;
        tick();
        checks++;
        if ({vld_a, vld_b} !== 2'b00) begin
            failures++;
            $display("FAIL flush_late: got valid_a=%b valid_b=%b want 0 0", vld_a, vld_b);
        end
        read_en      = 1'b1;
        read_address = 10'd999;
        tick();
        idle();
        checks++;
        if ({vld_b, dout_b} !== {1'b1, 32'h99999999}) begin
            failures++;
            $display("FAIL retain_b: got valid=%b data=%h want valid=1 data=99999999",
                     vld_b, dout_b);
        end
        tick();
        checks++;
        if ({vld_a, dout_a} !== {1'b1, 32'h99999999}) begin
            failures++;
            $display("FAIL retain_a: got valid=%b data=%h want valid=1 data=99999999",
                     vld_a, dout_a);
        end
    endtask

`ifdef PIPELINED_DUAL_PORT_MEMORY_PARITY_EN
    task automatic test_parity();
        parity_inject = 1'b1;
        do_write(10'd3, 32'h000000AA, 4'b0001);
        parity_inject = 1'b0;
        read_en      = 1'b1;
        read_address = 10'd3;
        tick();
        idle();
        checks++;
        if ({vld_b, perr_b, dout_b} !== {2'b11, 32'hC0DE00AA}) begin
            failures++;
            $display("FAIL perr_b: got valid=%b perr=%b data=%h want 1 1 c0de00aa",
                     vld_b, perr_b, dout_b);
        end
        tick();
        checks++;
        if ({vld_a, perr_a} !== 2'b11) begin
            failures++;
            $display("FAIL perr_a: got valid=%b perr=%b want 1 1", vld_a, perr_a);
        end
        read_en      = 1'b1;
        read_address = 10'd4;
        tick();
        idle();
        checks++;
        if ({vld_b, perr_b} !== 2'b10) begin
            failures++;
            $display("FAIL clean_b: got valid=%b perr=%b want 1 0", vld_b, perr_b);
        end
        tick();
        checks++;
        if ({vld_a, perr_a} !== 2'b10) begin
            failures++;
            $display("FAIL clean_a: got valid=%b perr=%b want 1 0", vld_a, perr_a);
        end
    endtask
`endif

    initial begin
        reset         = 1'b1;
        write_address = '0;
        read_address  = '0;
        data_in       = '0;
`ifdef PIPELINED_DUAL_PORT_MEMORY_PARITY_EN
        parity_inject = 1'b0;
`endif
        idle();
        test_reset();
        test_write_read();
        test_rdw();
        test_back_to_back();
        test_out_of_range();
        test_reset_flush();
`ifdef PIPELINED_DUAL_PORT_MEMORY_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
